// File: rtl/display_pkg.sv
// Shared display geometry, framebuffer bus widths and arbiter state encoding.
package display_pkg;

    localparam int unsigned CORDW      = 11;
    localparam int unsigned V_RES      = 768;
    localparam int unsigned LINE_WORDS = 128;
    localparam int unsigned DATAW      = 8;
    localparam int unsigned ADDRW      = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// CPU write, framebuffer port and line-buffer write bundle around fb_arbiter.
interface fb_arbiter_if import display_pkg::*; #(
    parameter int unsigned AW  = ADDRW,
    parameter int unsigned DW  = DATAW,
    parameter int unsigned LBW = $clog2(LINE_WORDS) + 1
);

    logic          cpu_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic           lb_we;
    logic [LBW-1:0] lb_addr;
    logic [DW-1:0]  lb_wdata;

    // arbiter side: owns the framebuffer port and the line-buffer write port
    modport master (
        input  cpu_valid, cpu_addr, cpu_data, mem_rdata,
        output cpu_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output lb_we, lb_addr, lb_wdata
    );

    // environment side: CPU, framebuffer RAM and line buffer
    modport slave (
        output cpu_valid, cpu_addr, cpu_data, mem_rdata,
        input  cpu_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  lb_we, lb_addr, lb_wdata
    );

endinterface

// File: rtl/fb_arbiter.sv
// Shares one framebuffer port between next-line prefetch into a two-bank
// line buffer (priority) and CPU writes.
module fb_arbiter #(
    parameter int unsigned CORDW      = display_pkg::CORDW,
    parameter int unsigned V_RES      = display_pkg::V_RES,
    parameter int unsigned LINE_WORDS = display_pkg::LINE_WORDS,
    parameter int unsigned DATAW      = display_pkg::DATAW,
    parameter int unsigned ADDRW      = display_pkg::ADDRW
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sy,
    fb_arbiter_if.master            bus,
    output logic                    busy,
    output logic                    overrun
);
    import display_pkg::*;

    localparam int unsigned WCW  = $clog2(LINE_WORDS);
    localparam int unsigned YW   = ADDRW - WCW;
    localparam int unsigned LBAW = WCW + 1;

    localparam logic signed [CORDW-1:0] SY_MIN = CORDW'(-1);
    localparam logic signed [CORDW-1:0] SY_MAX = CORDW'(V_RES - 2);

    fb_state_t        state_q, state_d;
    logic [WCW-1:0]   wc_q, wc_d;
    logic [YW-1:0]    ysel_q, ysel_d;

    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
    logic [DATAW-1:0] mem_wdata_q, mem_wdata_d;

    logic             lb_we_q;
    logic [LBAW-1:0]  lb_addr_q;
    logic             busy_q;
    logic             overrun_q;

    logic             trigger;
    logic             cpu_ready;

    // A line pulse starts a fetch only from IDLE and only for a line whose successor is on screen
    assign trigger   = line && (state_q == IDLE) && (sy >= SY_MIN) && (sy <= SY_MAX);
    assign cpu_ready = bus.cpu_valid && (state_q == IDLE) && !trigger;

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        ysel_d      = ysel_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = FETCH;
                    wc_d    = '0;
                    ysel_d  = YW'(sy + CORDW'(1));
                end else if (cpu_ready) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_data;
                end
            end
            FETCH: begin
                mem_en_d   = 1'b1;
                mem_addr_d = {ysel_q, wc_q};
                // hold wc on the last word instead of letting it wrap
                if (wc_q == WCW'(LINE_WORDS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    wc_d = wc_q + WCW'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
                wc_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q     <= IDLE;
            wc_q        <= '0;
            ysel_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            ysel_q      <= ysel_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            // read data lands one cycle after the read; low address bits are {ysel[0], wc}
            lb_we_q     <= mem_en_q && !mem_we_q;
            lb_addr_q   <= mem_addr_q[LBAW-1:0];
            busy_q      <= (state_d != IDLE);
            if (line && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.cpu_ready = cpu_ready;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.lb_we     = lb_we_q;
    assign bus.lb_addr   = lb_addr_q;
    assign bus.lb_wdata  = bus.mem_rdata;
    assign busy          = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized self-checking bench for fb_arbiter against a transaction-level model.
module tb_fb_arbiter;
    import display_pkg::*;

    localparam int unsigned WCW  = $clog2(LINE_WORDS);
    localparam int unsigned LBAW = WCW + 1;
    localparam int          LW   = int'(LINE_WORDS);
    localparam int          FETCH_CYC = LW + 2;

    logic                    clk_pix = 1'b0;
    logic                    rst_pix;
    logic                    line;
    logic signed [CORDW-1:0] sy;
    logic                    busy;
    logic                    overrun;

    fb_arbiter_if #(.AW(ADDRW), .DW(DATAW), .LBW(LBAW)) bus ();

    fb_arbiter #(
        .CORDW(CORDW), .V_RES(V_RES), .LINE_WORDS(LINE_WORDS),
        .DATAW(DATAW), .ADDRW(ADDRW)
    ) dut (
        .clk_pix(clk_pix),
        .rst_pix(rst_pix),
        .line(line),
        .sy(sy),
        .bus(bus.master),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    ev_t rd_q[$], wr_q[$], lb_q[$], acc_q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  seed;
    logic [DATAW-1:0] mem_map [int];
    logic [DATAW-1:0] ref_map [int];

    function automatic logic [DATAW-1:0] pat(int a);
        return DATAW'((a * 37) ^ (a >>> 6) ^ seed);
    endfunction

    function automatic logic [DATAW-1:0] exp_ram(int a);
        if (ref_map.exists(a)) return ref_map[a];
        return pat(a);
    endfunction

    function automatic ev_t mk(int c, int a, int d);
        ev_t e;
        e.cyc = c; e.addr = a; e.data = d;
        return e;
    endfunction

    always @(posedge clk_pix) cyc <= cyc + 1;

    // framebuffer RAM: synchronous, read data one cycle after the read
    always @(posedge clk_pix) begin
        int a;
        a = int'(bus.mem_addr);
        if (bus.mem_en) begin
            if (bus.mem_we) mem_map[a] = bus.mem_wdata;
            else bus.mem_rdata <= mem_map.exists(a) ? mem_map[a] : pat(a);
        end
    end

    always @(negedge clk_pix) begin
        if (bus.mem_en && !bus.mem_we) rd_q.push_back(mk(cyc, int'(bus.mem_addr), 0));
        if (bus.mem_en && bus.mem_we)
            wr_q.push_back(mk(cyc, int'(bus.mem_addr), int'(bus.mem_wdata)));
        if (bus.lb_we) lb_q.push_back(mk(cyc, int'(bus.lb_addr), int'(bus.lb_wdata)));
        if (bus.cpu_valid && bus.cpu_ready)
            acc_q.push_back(mk(cyc, int'(bus.cpu_addr), int'(bus.cpu_data)));
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(output bit acc);
        @(negedge clk_pix);
        acc = bus.cpu_valid && bus.cpu_ready;
        @(posedge clk_pix);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(a);
    endtask

    task automatic clear_q();
        rd_q.delete(); wr_q.delete(); lb_q.delete(); acc_q.delete();
    endtask

    task automatic pulse(input int s, output int tc, output bit acc);
        line = 1'b1;
        sy   = CORDW'(s);
        tc   = cyc;
        step(acc);
        line = 1'b0;
    endtask

    // cycles from the trigger cycle until busy falls
    task automatic wait_idle(output int n);
        bit a;
        n = 1;
        while (busy && n < 1000) begin
            step(a);
            n++;
        end
    endtask

    task automatic check_fetch(input string tag, input int ysel, input int tc);
        int n;
        chk({tag, "_nrd"}, rd_q.size(), LW);
        chk({tag, "_nlb"}, lb_q.size(), LW);
        n = (rd_q.size() < lb_q.size()) ? rd_q.size() : lb_q.size();
        if (n > LW) n = LW;
        if (n > 0) chk({tag, "_rd_lat"}, rd_q[0].cyc - tc, 2);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_rd_addr"}, rd_q[i].addr, ysel * LW + i);
            chk({tag, "_lb_addr"}, lb_q[i].addr, (ysel % 2) * LW + i);
            chk({tag, "_lb_data"}, lb_q[i].data, int'(exp_ram(ysel * LW + i)));
            chk({tag, "_lb_cyc"}, lb_q[i].cyc, rd_q[i].cyc + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tc, n, k, nready, s, free, errs;
        bit  a, exp_ovr;
        int  req_a[$], req_d[$], pc[$], ps[$], trig[$], ys[$];
        int  ba[10], bd[10];

        seed = int'($urandom);
        rst_pix = 1'b1; line = 1'b0; sy = '0;
        bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_lb_we", bus.lb_we, 0);
        chk("rst_lb_addr", bus.lb_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge clk_pix); #1;
        rst_pix = 1'b0;
        idle(2);

        // first line fetch from the line before the top of screen
        clear_q();
        pulse(-1, tc, a);
        wait_idle(n);
        chk("s1_len", n, FETCH_CYC);
        idle(2);
        check_fetch("s1", 0, tc);

        // last line pulse is ignored; the one before fetches the last line into bank 1
        clear_q();
        pulse(int'(V_RES) - 1, tc, a);
        idle(5);
        chk("s2_busy", busy, 0);
        chk("s2_nrd", rd_q.size(), 0);
        clear_q();
        pulse(int'(V_RES) - 2, tc, a);
        wait_idle(n);
        chk("s2_len", n, FETCH_CYC);
        idle(2);
        check_fetch("s2", int'(V_RES) - 1, tc);

        // CPU write colliding with a trigger waits out the whole fetch
        clear_q();
        bus.cpu_valid = 1'b1; bus.cpu_addr = ADDRW'(17'h00010); bus.cpu_data = 8'hA5;
        line = 1'b1; sy = CORDW'(4); tc = cyc; nready = 0;
        do begin
            step(a);
            line = 1'b0;
            if (!a) nready++;
        end while (!a && nready < 400);
        bus.cpu_valid = 1'b0;
        ref_map[16] = 8'hA5;
        chk("s3_wait", nready, FETCH_CYC);
        idle(3);
        chk("s3_nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            chk("s3_wr_addr", wr_q[0].addr, 16);
            chk("s3_wr_data", wr_q[0].data, 'hA5);
            chk("s3_wr_cyc", wr_q[0].cyc - tc, FETCH_CYC + 1);
        end
        chk("s3_ram", mem_map.exists(16) ? int'(mem_map[16]) : -1, 'hA5);
        check_fetch("s3", 5, tc);

        // back-to-back CPU writes in IDLE
        clear_q();
        for (int i = 0; i < 10; i++) begin
            ba[i] = 98304 + int'($urandom_range(0, 32767));
            bd[i] = int'($urandom_range(0, 255));
            bus.cpu_valid = 1'b1;
            bus.cpu_addr  = ADDRW'(ba[i]);
            bus.cpu_data  = DATAW'(bd[i]);
            step(a);
            chk("s4_ready", a, 1);
            ref_map[ba[i]] = DATAW'(bd[i]);
        end
        bus.cpu_valid = 1'b0;
        idle(2);
        chk("s4_nwr", wr_q.size(), 10);
        chk("s4_nacc", acc_q.size(), 10);
        if (wr_q.size() == 10 && acc_q.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk("s4_wr_addr", wr_q[i].addr, ba[i]);
                chk("s4_wr_data", wr_q[i].data, bd[i]);
                chk("s4_wr_lat", wr_q[i].cyc, acc_q[i].cyc + 1);
                chk("s4_no_gap", wr_q[i].cyc, wr_q[0].cyc + i);
            end
        end

        // second line pulse mid-fetch: fetch unchanged, overrun sticky until reset
        clear_q();
        pulse(10, tc, a);
        idle(49);
        pulse(20, n, a);
        k = 0;
        while (busy && k < 400) begin step(a); k++; end
        idle(5);
        check_fetch("s5", 11, tc);
        chk("s5_overrun", overrun, 1);
        chk("s5_busy", busy, 0);
        rst_pix = 1'b1;
        step(a);
        rst_pix = 1'b0;
        chk("s5_ovr_clr", overrun, 0);

        // reset mid-fetch aborts; next fetch restarts from word 0
        clear_q();
        pulse(20, tc, a);
        k = 0;
        while (rd_q.size() < 60 && k < 300) begin step(a); k++; end
        rst_pix = 1'b1;
        step(a);
        rst_pix = 1'b0;
        @(negedge clk_pix);
        chk("s6_mem_en", bus.mem_en, 0);
        chk("s6_lb_we", bus.lb_we, 0);
        chk("s6_busy", busy, 0);
        @(posedge clk_pix); #1;
        clear_q();
        pulse(20, tc, a);
        wait_idle(n);
        chk("s6_len", n, FETCH_CYC);
        idle(2);
        check_fetch("s6", 21, tc);

        // random line pulses and CPU traffic; CPU writes stay above the fetchable area
        clear_q();
        for (int i = 0; i < 3000; i++) begin
            line = 1'b0;
            if (i < 2700 && $urandom_range(0, 39) == 0) begin
                s = int'($urandom_range(0, 803)) - 3;
                line = 1'b1;
                sy = CORDW'(s);
                pc.push_back(cyc);
                ps.push_back(s);
            end
            if (!bus.cpu_valid && i < 2700 && $urandom_range(0, 2) == 0) begin
                req_a.push_back(98304 + int'($urandom_range(0, 32767)));
                req_d.push_back(int'($urandom_range(0, 255)));
                bus.cpu_valid = 1'b1;
                bus.cpu_addr  = ADDRW'(req_a[$]);
                bus.cpu_data  = DATAW'(req_d[$]);
            end
            step(a);
            if (a) begin
                bus.cpu_valid = 1'b0;
                ref_map[int'(bus.cpu_addr)] = bus.cpu_data;
            end
        end
        line = 1'b0;
        idle(3);

        free = -1000000; exp_ovr = 1'b0;
        foreach (pc[j]) begin
            if (pc[j] < free) exp_ovr = 1'b1;
            else if (ps[j] >= -1 && ps[j] <= int'(V_RES) - 2) begin
                trig.push_back(pc[j]);
                ys.push_back(ps[j] + 1);
                free = pc[j] + FETCH_CYC;
            end
        end
        chk("rnd_overrun", overrun, exp_ovr);
        chk("rnd_nrd", rd_q.size(), trig.size() * LW);
        chk("rnd_nlb", lb_q.size(), trig.size() * LW);
        errs = 0;
        if (rd_q.size() == trig.size() * LW && lb_q.size() == rd_q.size()) begin
            foreach (trig[j]) begin
                for (int i = 0; i < LW; i++) begin
                    k = j * LW + i;
                    if (rd_q[k].addr != ys[j] * LW + i) errs++;
                    if (rd_q[k].cyc != trig[j] + 2 + i) errs++;
                    if (lb_q[k].addr != (ys[j] % 2) * LW + i) errs++;
                    if (lb_q[k].data != int'(exp_ram(ys[j] * LW + i))) errs++;
                end
            end
        end
        chk("rnd_fetch_errs", errs, 0);
        chk("rnd_nacc", acc_q.size(), req_a.size());
        chk("rnd_nwr", wr_q.size(), req_a.size());
        errs = 0;
        if (acc_q.size() == req_a.size() && wr_q.size() == req_a.size()) begin
            foreach (req_a[i]) begin
                if (wr_q[i].addr != req_a[i] || wr_q[i].data != req_d[i]) errs++;
                if (wr_q[i].cyc != acc_q[i].cyc + 1) errs++;
                foreach (trig[j])
                    if (acc_q[i].cyc >= trig[j] && acc_q[i].cyc < trig[j] + FETCH_CYC) errs++;
            end
        end
        chk("rnd_cpu_errs", errs, 0);
        errs = 0;
        foreach (ref_map[ad])
            if (!mem_map.exists(ad) || mem_map[ad] != ref_map[ad]) errs++;
        chk("rnd_ram_errs", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
